// File: rtl/cpu_subsys_timer_if.sv
// Peripheral memory bus between the CPU subsystem decoder and the machine timer.
// Master holds a request stable until a single-cycle mem_ready completion pulse.
interface cpu_subsys_timer_if #(
  parameter int ADDR_W = 3
);
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_valid, mem_addr, mem_write, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_write, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_subsys_timer.sv
// Machine timer: prescaled 64-bit mtime vs mtimecmp, level irq_timer to the core.
// Fixed 1-cycle bus latency; a new request is taken only while mem_ready is low.
module cpu_subsys_timer #(
  parameter int          ADDR_W    = 3,
  parameter int          PRESC_W   = 16,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  cpu_subsys_timer_if.slave        bus,
  output logic                     irq_timer
);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_MT_LO  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_MT_HI  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(6);

  logic [1:0]         ctrl;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic [31:0]        hi_shadow;
  logic               pending;

  logic               accept, wr_en, rd_en;
  logic               wr_ctrl, wr_presc, wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi, wr_status;
  logic               tick, cmp_hit, pending_nxt;
  logic [1:0]         ctrl_nxt;
  logic [PRESC_W-1:0] presc_nxt;
  logic [63:0]        mtime_nxt;
  logic [31:0]        rd_val;

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = st[b] ? wd[b*8 +: 8] : cur[b*8 +: 8];
    return r;
  endfunction

  assign accept = bus.mem_valid & ~bus.mem_ready;
  assign wr_en  = accept & bus.mem_write;
  assign rd_en  = accept & ~bus.mem_write;

  assign wr_ctrl   = wr_en & (bus.mem_addr == A_CTRL);
  assign wr_presc  = wr_en & (bus.mem_addr == A_PRESC);
  assign wr_mt_lo  = wr_en & (bus.mem_addr == A_MT_LO);
  assign wr_mt_hi  = wr_en & (bus.mem_addr == A_MT_HI);
  assign wr_cmp_lo = wr_en & (bus.mem_addr == A_CMP_LO);
  assign wr_cmp_hi = wr_en & (bus.mem_addr == A_CMP_HI);
  assign wr_status = wr_en & (bus.mem_addr == A_STATUS);

  assign tick    = ctrl[0] & (pcnt == presc);
  assign cmp_hit = mtime >= mtimecmp;
  // Compare hit takes priority over a concurrent write-1-to-clear.
  assign pending_nxt = cmp_hit |
                       (pending & ~(wr_status & bus.mem_wstrb[0] & bus.mem_wdata[0]));

  assign ctrl_nxt = bus.mem_wstrb[0] ? bus.mem_wdata[1:0] : ctrl;

  always_comb begin
    presc_nxt = presc;
    for (int i = 0; i < PRESC_W; i++)
      presc_nxt[i] = bus.mem_wstrb[i/8] ? bus.mem_wdata[i] : presc[i];
  end

  // A bus write to either half suppresses that cycle's tick for the whole counter.
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    if (wr_mt_lo)
      mtime_nxt = {mtime[63:32], merge(mtime[31:0], bus.mem_wdata, bus.mem_wstrb)};
    if (wr_mt_hi)
      mtime_nxt = {merge(mtime[63:32], bus.mem_wdata, bus.mem_wstrb), mtime[31:0]};
  end

  always_comb begin
    rd_val = '0;
    case (bus.mem_addr)
      A_CTRL:   rd_val = {30'd0, ctrl};
      A_PRESC:  rd_val = 32'(presc);
      A_MT_LO:  rd_val = mtime[31:0];
      A_MT_HI:  rd_val = hi_shadow;
      A_CMP_LO: rd_val = mtimecmp[31:0];
      A_CMP_HI: rd_val = mtimecmp[63:32];
      A_STATUS: rd_val = {31'd0, pending};
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      irq_timer     <= 1'b0;
      ctrl          <= '0;
      presc         <= '0;
      pcnt          <= '0;
      mtime         <= '0;
      mtimecmp      <= CMP_RESET;
      hi_shadow     <= '0;
      pending       <= 1'b0;
    end else begin
      bus.mem_ready <= accept;
      bus.mem_rdata <= rd_en ? rd_val : 32'd0;
      if (wr_ctrl) ctrl <= ctrl_nxt;
      if (wr_presc) begin
        presc <= presc_nxt;
        pcnt  <= '0;
      end else if (ctrl[0]) begin
        pcnt  <= tick ? '0 : pcnt + PRESC_W'(1);
      end
      mtime <= mtime_nxt;
      if (wr_cmp_lo)
        mtimecmp[31:0]  <= merge(mtimecmp[31:0], bus.mem_wdata, bus.mem_wstrb);
      if (wr_cmp_hi)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.mem_wdata, bus.mem_wstrb);
      // Latch the upper half so a LO-then-HI read pair is coherent across a carry.
      if (rd_en && bus.mem_addr == A_MT_LO) hi_shadow <= mtime[63:32];
      pending   <= pending_nxt;
      irq_timer <= ctrl[1] & pending_nxt;
    end
  end
endmodule

// File: tb/tb_cpu_subsys_timer.sv
// Randomized bench for cpu_subsys_timer; expected mtime values come from elapsed
// cycle arithmetic (ticks = floor(cycles / (PRESC+1))), not from a per-cycle copy.
module tb_cpu_subsys_timer;
  localparam int ADDR_W  = 3;
  localparam int PRESC_W = 16;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic irq_timer;

  cpu_subsys_timer_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_subsys_timer #(
    .ADDR_W(ADDR_W), .PRESC_W(PRESC_W), .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .bus(bus), .irq_timer(irq_timer)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned last_acc;
  int          last_lat;
  logic        last_rdy_after;
  logic        last_irq;

  function automatic logic [31:0] rst_val(input int off);
    return (off == 4 || off == 5) ? 32'hFFFF_FFFF : 32'h0;
  endfunction

  function automatic logic [31:0] strobe_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the ready pulse.
  task automatic xfer(input logic wr, input int off, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd);
    bus.mem_valid = 1'b1;
    bus.mem_write = wr;
    bus.mem_addr  = ADDR_W'(off);
    bus.mem_wdata = wd;
    bus.mem_wstrb = st;
    last_lat = 0;
    do begin
      @(negedge sys_clk);
      last_lat++;
    end while (bus.mem_ready !== 1'b1 && last_lat < 8);
    rd       = bus.mem_rdata;
    last_acc = cyc;
    last_irq = irq_timer;
    if (bus.mem_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: off=%0d no mem_ready after %0d cycles, need 1", off, last_lat);
      last_lat = 0;
    end
    bus.mem_valid = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    @(negedge sys_clk);
    last_rdy_after = bus.mem_ready;
  endtask

  task automatic reg_wr(input int off, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] d;
    xfer(1'b1, off, wd, st, d);
  endtask

  task automatic reg_rd(input int off, output logic [31:0] d);
    xfer(1'b0, off, 32'h0, 4'h0, d);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    vectors++;
    if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0 || irq_timer !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b rdata=%h irq=%b, need 0/0/0",
               bus.mem_ready, bus.mem_rdata, irq_timer);
    end
    rst = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      reg_rd(i, d);
      vectors++;
      if (d !== rst_val(i)) begin
        miscompares++;
        $display("FAIL reset_read[%0d]: got %h, need %h", i, d, rst_val(i));
      end
      vectors++;
      if (last_lat != 1 || last_rdy_after !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_timing[%0d]: latency=%0d ready_next=%b, need 1 and 0",
                 i, last_lat, last_rdy_after);
      end
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] d, lo, hi, exp_v, frozen;
    int unsigned p, a, r, dc;
    for (int it = 0; it < 3; it++) begin
      p  = (it == 0) ? 3 : $urandom_range(0, 4);
      lo = $urandom_range(0, 1000);
      hi = $urandom_range(0, 32'hFFFF);
      reg_wr(0, 32'h0, 4'hF);
      reg_wr(1, p, 4'hF);
      reg_wr(2, lo, 4'hF);
      reg_wr(3, hi, 4'hF);
      reg_wr(0, 32'h1, 4'hF);
      a = last_acc;
      repeat ($urandom_range(10, 40)) @(negedge sys_clk);
      reg_rd(2, d);
      r = last_acc;
      exp_v = lo + (r - 1 - a) / (p + 1);
      vectors++;
      if (d !== exp_v) begin
        miscompares++;
        $display("FAIL presc_count p=%0d: got %0d, need %0d", p, d, exp_v);
      end
      reg_wr(0, 32'h0, 4'hF);
      dc = last_acc;
      frozen = lo + (dc - a) / (p + 1);
      repeat (20) @(negedge sys_clk);
      reg_rd(2, d);
      vectors++;
      if (d !== frozen) begin
        miscompares++;
        $display("FAIL presc_frozen p=%0d: got %0d, need %0d", p, d, frozen);
      end
      reg_rd(3, d);
      vectors++;
      if (d !== hi) begin
        miscompares++;
        $display("FAIL presc_hi_shadow: got %h, need %h", d, hi);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [63:0] m;
    int unsigned a, r;
    reg_wr(0, 32'h0, 4'hF);
    reg_wr(1, 32'h0, 4'hF);
    reg_wr(2, 32'hFFFF_FFFF, 4'hF);
    reg_wr(3, 32'h0, 4'hF);
    reg_wr(0, 32'h1, 4'hF);
    a = last_acc;
    reg_rd(2, d);
    r = last_acc;
    m = 64'h0000_0000_FFFF_FFFF + 64'(r - 1 - a);
    vectors++;
    if (d !== m[31:0]) begin
      miscompares++;
      $display("FAIL wrap_lo: got %h, need %h", d, m[31:0]);
    end
    reg_rd(3, d);
    vectors++;
    if (d !== m[63:32]) begin
      miscompares++;
      $display("FAIL wrap_hi_shadow: got %h, need %h", d, m[63:32]);
    end
    reg_rd(2, d);
    r = last_acc;
    m = 64'h0000_0000_FFFF_FFFF + 64'(r - 1 - a);
    reg_wr(3, $urandom_range(2, 1000), 4'hF);
    reg_rd(3, d);
    vectors++;
    if (d !== m[63:32]) begin
      miscompares++;
      $display("FAIL shadow_after_hi_write: got %h, need %h", d, m[63:32]);
    end
    reg_wr(0, 32'h0, 4'hF);
  endtask

  task automatic test_compare();
    logic [31:0] d;
    int unsigned t, a, seen;
    logic irq_before;
    t = $urandom_range(10, 30);
    reg_wr(0, 32'h0, 4'hF);
    reg_wr(2, 32'h0, 4'hF);
    reg_wr(3, 32'h0, 4'hF);
    reg_wr(1, 32'h0, 4'hF);
    reg_wr(5, 32'h0, 4'hF);
    reg_wr(4, t, 4'hF);
    reg_wr(6, 32'h1, 4'hF);
    reg_rd(6, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL cmp_pending_early: got %h, need 0", d);
    end
    reg_wr(0, 32'h3, 4'hF);
    a = last_acc;
    seen = 0;
    for (int k = 0; k < int'(t) + 20; k++) begin
      if (irq_timer === 1'b1) begin
        seen = cyc;
        break;
      end
      @(negedge sys_clk);
    end
    vectors++;
    if (seen != a + t + 1) begin
      miscompares++;
      $display("FAIL irq_rise cmp=%0d: rose at cycle offset %0d, need %0d", t, seen - a, t + 1);
    end
    reg_rd(6, d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL cmp_pending_set: got %h, need 1", d);
    end
    reg_wr(6, 32'h1, 4'hF);
    reg_rd(6, d);
    vectors++;
    if (d !== 32'h1 || irq_timer !== 1'b1) begin
      miscompares++;
      $display("FAIL w1c_while_hit: pending=%h irq=%b, need 1/1", d, irq_timer);
    end
    reg_wr(4, 32'hFFFF_FFFF, 4'hF);
    reg_wr(5, 32'hFFFF_FFFF, 4'hF);
    irq_before = irq_timer;
    reg_wr(6, 32'h1, 4'hF);
    vectors++;
    if (irq_before !== 1'b1 || last_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL w1c_clear_irq: irq before=%b after=%b, need 1 then 0", irq_before, last_irq);
    end
    reg_rd(6, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL w1c_pending_cleared: got %h, need 0", d);
    end
    reg_wr(0, 32'h0, 4'hF);
  endtask

  task automatic test_strobes();
    logic [31:0] d, old, wd, exp_v;
    logic [3:0]  st;
    int          off;
    reg_wr(2, 32'h0, 4'hF);
    reg_wr(2, 32'h1234_5678, 4'b0011);
    reg_rd(2, d);
    vectors++;
    if (d !== 32'h0000_5678) begin
      miscompares++;
      $display("FAIL strobe_lo_fixed: got %h, need 00005678", d);
    end
    for (int it = 0; it < 8; it++) begin
      off = $urandom_range(2, 5);
      old = $urandom;
      wd  = $urandom;
      st  = 4'($urandom_range(0, 15));
      if (off == 3) old[31] = 1'b0;
      reg_wr(off, old, 4'hF);
      reg_wr(off, wd, st);
      if (off == 3) reg_rd(2, d);
      reg_rd(off, d);
      exp_v = strobe_merge(old, wd, st);
      vectors++;
      if (d !== exp_v) begin
        miscompares++;
        $display("FAIL strobe_rand off=%0d st=%b: got %h, need %h", off, st, d, exp_v);
      end
    end
    old = $urandom;
    wd  = $urandom;
    st  = 4'($urandom_range(0, 15));
    reg_wr(1, old, 4'hF);
    reg_wr(1, wd, st);
    reg_rd(1, d);
    exp_v = strobe_merge(old, wd, st) & 32'h0000_FFFF;
    vectors++;
    if (d !== exp_v) begin
      miscompares++;
      $display("FAIL strobe_presc st=%b: got %h, need %h", st, d, exp_v);
    end
    wd = $urandom;
    wd[0] = 1'b0;
    reg_wr(0, wd, 4'hF);
    reg_rd(0, d);
    vectors++;
    if (d !== (wd & 32'h3)) begin
      miscompares++;
      $display("FAIL ctrl_raz: got %h, need %h", d, wd & 32'h3);
    end
    reg_wr(0, 32'h0, 4'hF);
    reg_wr(7, $urandom, 4'hF);
    vectors++;
    if (last_lat != 1) begin
      miscompares++;
      $display("FAIL unmapped_write_ready: latency %0d, need 1", last_lat);
    end
    reg_rd(7, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_read: got %h, need 0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, wd;
    int unsigned a;
    wd = 32'($urandom_range(0, 16'hFFFF));
    reg_wr(1, wd, 4'hF);
    a = last_acc;
    reg_rd(1, d);
    vectors++;
    if (d !== wd || last_acc != a + 2 || last_rdy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back: data=%h spacing=%0d ready_next=%b, need %h/2/0",
               d, last_acc - a, last_rdy_after, wd);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    reg_wr(2, 32'h0, 4'hF);
    reg_wr(3, 32'h0, 4'hF);
    reg_wr(4, 32'h0, 4'hF);
    reg_wr(5, 32'h0, 4'hF);
    reg_wr(0, 32'h2, 4'hF);
    repeat (2) @(negedge sys_clk);
    vectors++;
    if (irq_timer !== 1'b1) begin
      miscompares++;
      $display("FAIL midflight_irq_setup: irq=%b, need 1", irq_timer);
    end
    bus.mem_valid = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_addr  = ADDR_W'(1);
    bus.mem_wdata = 32'h5;
    bus.mem_wstrb = 4'hF;
    @(posedge sys_clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (bus.mem_ready !== 1'b0 || irq_timer !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midflight_async: ready=%b irq=%b rdata=%h, need 0/0/0",
               bus.mem_ready, irq_timer, bus.mem_rdata);
    end
    bus.mem_valid = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if (bus.mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_no_ready: ready=%b, need 0", bus.mem_ready);
    end
    for (int i = 0; i < 8; i++) begin
      reg_rd(i, d);
      vectors++;
      if (d !== rst_val(i)) begin
        miscompares++;
        $display("FAIL midflight_read[%0d]: got %h, need %h", i, d, rst_val(i));
      end
    end
  endtask

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    test_reset();
    test_prescaler();
    test_wrap();
    test_compare();
    test_strobes();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
